ex_alu_muldiv: RTL and testbench

Parametrised execute-stage ALU, successor to the single-cycle execute block. Contains operand forwarding muxes, an immediate select, a branch-target adder and branch compare. Adds an iterative multiply/divide unit with a valid/ready handshake, so the hazard unit stalls issue while a long operation runs. Sits between the ID/EX and EX/DM pipeline registers, and its result output is registered.

---
 rtl/ex_alu_pkg.sv | 47 ++++
 rtl/ex_alu_muldiv_iter_muldiv.sv | 136 +++++++++++++
 rtl/ex_alu_muldiv.sv | 178 +++++++++++++++++
 tb/tb_ex_alu_muldiv.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_alu_pkg.sv
// Shared types for the execute-stage ALU and its iterative multiply/divide unit.
package ex_alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_SLT  = 4'd5,
      OP_SLL  = 4'd6,
      OP_SRL  = 4'd7,
      OP_SRA  = 4'd8,
      OP_MUL  = 4'd9,
      OP_MULH = 4'd10,
      OP_DIV  = 4'd11,
      OP_REM  = 4'd12,
      OP_R13  = 4'd13,
      OP_R14  = 4'd14,
      OP_R15  = 4'd15
   } alu_op_e;

   typedef enum logic [1:0] {
      FWD_RF   = 2'd0,
      FWD_EXDM = 2'd1,
      FWD_DMWB = 2'd2,
      FWD_RSVD = 2'd3
   } fwd_sel_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } md_state_e;

   // True for opcodes that go through the iterative multiply/divide unit.
   function automatic logic is_multicycle(input alu_op_e op);
      logic r;
      case (op)
         OP_MUL, OP_MULH, OP_DIV, OP_REM: r = 1'b1;
         default:                         r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ex_alu_muldiv_iter_muldiv.sv
// Iterative radix-2 multiply / restoring divide on operand magnitudes.
// One preparation step converts operands to magnitudes, then XLEN
// iterations run; the sign-corrected result is presented combinationally
// once the unit goes idle.
module iter_muldiv
   import ex_alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic            flush_i,
   input  alu_op_e         op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int CNT_W = $clog2(XLEN) + 1;

   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             isDiv_q, isDiv_d;
   logic             wantHi_q, wantHi_d;
   logic             bNeg_q, bNeg_d;
   logic [XLEN-1:0]  a_q, a_d;
   logic [XLEN-1:0]  b_q, b_d;
   logic [XLEN-1:0]  hi_q, hi_d;
   logic [XLEN-1:0]  lo_q, lo_d;

   logic             aNeg;
   logic [XLEN:0]    mulSum;
   logic [XLEN:0]    divTrial;
   logic [XLEN:0]    divDiff;
   logic [2*XLEN-1:0] prodSigned;
   logic [XLEN-1:0]  quo;
   logic [XLEN-1:0]  rem;

   assign aNeg   = a_q[XLEN-1];
   assign done_o = busy_q && (cnt_q == CNT_W'(XLEN));

   // Step logic: on start latch raw operands, then one magnitude-prep
   // step followed by XLEN shift-add or shift-subtract iterations.
   always_comb begin
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      isDiv_d  = isDiv_q;
      wantHi_d = wantHi_q;
      bNeg_d   = bNeg_q;
      a_d      = a_q;
      b_d      = b_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
      divTrial = {hi_q, lo_q[XLEN-1]};
      divDiff  = divTrial - {1'b0, b_q};
      if (flush_i) begin
         busy_d = 1'b0;
         cnt_d  = '0;
      end else if (start_i) begin
         busy_d   = 1'b1;
         cnt_d    = '0;
         isDiv_d  = (op_i == OP_DIV) || (op_i == OP_REM);
         wantHi_d = (op_i == OP_MULH) || (op_i == OP_REM);
         bNeg_d   = b_i[XLEN-1];
         a_d      = a_i;
         b_d      = b_i;
      end else if (busy_q) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CNT_W'(XLEN)) begin
            busy_d = 1'b0;
         end
         if (cnt_q == '0) begin
            hi_d = '0;
            lo_d = aNeg ? (~a_q + 1'b1) : a_q;
            b_d  = bNeg_q ? (~b_q + 1'b1) : b_q;
         end else if (isDiv_q) begin
            if (divDiff[XLEN]) begin
               hi_d = divTrial[XLEN-1:0];
               lo_d = {lo_q[XLEN-2:0], 1'b0};
            end else begin
               hi_d = divDiff[XLEN-1:0];
               lo_d = {lo_q[XLEN-2:0], 1'b1};
            end
         end else begin
            hi_d = mulSum[XLEN:1];
            lo_d = {mulSum[0], lo_q[XLEN-1:1]};
         end
      end
   end

   // Register the datapath state; reset returns the unit to idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         isDiv_q  <= 1'b0;
         wantHi_q <= 1'b0;
         bNeg_q   <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         isDiv_q  <= isDiv_d;
         wantHi_q <= wantHi_d;
         bNeg_q   <= bNeg_d;
         a_q      <= a_d;
         b_q      <= b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   // Sign fix-up; a zero divisor yields all-ones quotient and the raw dividend as remainder.
   always_comb begin
      prodSigned = (aNeg ^ bNeg_q) ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
      if (b_q == '0) begin
         quo = '1;
         rem = a_q;
      end else begin
         quo = (aNeg ^ bNeg_q) ? (~lo_q + 1'b1) : lo_q;
         rem = aNeg ? (~hi_q + 1'b1) : hi_q;
      end
      if (isDiv_q) begin
         result_o = wantHi_q ? rem : quo;
      end else begin
         result_o = wantHi_q ? prodSigned[2*XLEN-1:XLEN] : prodSigned[XLEN-1:0];
      end
   end

endmodule

// File: rtl/ex_alu_muldiv.sv
// Execute-stage ALU: operand forwarding, immediate select, branch target
// and compare, single-cycle ALU ops and a handshaked iterative mul/div.
module ex_alu_muldiv
   import ex_alu_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int IMM_W    = 16,
   parameter int BR_SHIFT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [XLEN-1:0]  rs_val,
   input  logic [XLEN-1:0]  rt_val,
   input  logic [XLEN-1:0]  ex_dm_fwd,
   input  logic [XLEN-1:0]  dm_wb_fwd,
   input  logic [1:0]       fwd_a,
   input  logic [1:0]       fwd_b,
   input  logic             imm_sel,
   input  logic [IMM_W-1:0] imm,
   input  logic [XLEN-1:0]  pc_4,
   input  logic             is_branch,
   output logic             out_valid,
   output logic [XLEN-1:0]  result,
   output logic [XLEN-1:0]  branch_addr,
   output logic             branch_taken
);

   localparam int SH_W = $clog2(XLEN);

   md_state_e       state_q, state_d;
   logic            outValid_q, outValid_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [XLEN-1:0] brAddr_q, brAddr_d;
   logic            brTaken_q, brTaken_d;
   logic [XLEN-1:0] pendAddr_q, pendAddr_d;
   logic            pendTaken_q, pendTaken_d;

   alu_op_e         opE;
   logic [XLEN-1:0] opA, opBFwd, opB, immExt, aluRes, brAddrNow;
   logic [SH_W-1:0] shamt;
   logic            brTakenNow, accept, mdStart, mdDone;
   logic [XLEN-1:0] mdResult;

   assign opE        = alu_op_e'(op);
   assign immExt     = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
   assign opB        = imm_sel ? immExt : opBFwd;
   assign shamt      = opB[SH_W-1:0];
   assign brAddrNow  = pc_4 + (immExt << BR_SHIFT);
   assign brTakenNow = is_branch & (opA == opBFwd);
   assign in_ready   = (state_q == IDLE);
   assign accept     = in_valid & in_ready & ~flush;
   assign mdStart    = accept & is_multicycle(opE);

   assign out_valid    = outValid_q;
   assign result       = result_q;
   assign branch_addr  = brAddr_q;
   assign branch_taken = brTaken_q;

   // Forwarding muxes; the reserved select falls back to the register file.
   always_comb begin
      case (fwd_sel_e'(fwd_a))
         FWD_EXDM: opA = ex_dm_fwd;
         FWD_DMWB: opA = dm_wb_fwd;
         default:  opA = rs_val;
      endcase
      case (fwd_sel_e'(fwd_b))
         FWD_EXDM: opBFwd = ex_dm_fwd;
         FWD_DMWB: opBFwd = dm_wb_fwd;
         default:  opBFwd = rt_val;
      endcase
   end

   // Single-cycle ALU; unused opcodes behave as ADD.
   always_comb begin
      case (opE)
         OP_SUB:  aluRes = opA - opB;
         OP_AND:  aluRes = opA & opB;
         OP_OR:   aluRes = opA | opB;
         OP_XOR:  aluRes = opA ^ opB;
         OP_SLT:  aluRes = {{(XLEN-1){1'b0}}, ($signed(opA) < $signed(opB))};
         OP_SLL:  aluRes = opA << shamt;
         OP_SRL:  aluRes = opA >> shamt;
         OP_SRA:  aluRes = $unsigned($signed(opA) >>> shamt);
         default: aluRes = opA + opB;
      endcase
   end

   iter_muldiv #(
      .XLEN(XLEN)
   ) u_iter_muldiv (
      .clk      (clk),
      .rst      (rst),
      .start_i  (mdStart),
      .flush_i  (flush),
      .op_i     (opE),
      .a_i      (opA),
      .b_i      (opB),
      .done_o   (mdDone),
      .result_o (mdResult)
   );

   // Next-state logic for the long-operation sequencer; flush always wins.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (mdStart) begin
               state_d = (opE == OP_MUL || opE == OP_MULH) ? MUL : DIV;
            end
         end
         MUL, DIV: begin
            if (mdDone) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d = IDLE;
      end
   end

   // Output register updates: single-cycle ops complete at acceptance, long
   // ops park their branch outputs until DONE; outputs hold otherwise.
   always_comb begin
      outValid_d  = 1'b0;
      result_d    = result_q;
      brAddr_d    = brAddr_q;
      brTaken_d   = brTaken_q;
      pendAddr_d  = pendAddr_q;
      pendTaken_d = pendTaken_q;
      if (!flush) begin
         if (accept) begin
            if (is_multicycle(opE)) begin
               pendAddr_d  = brAddrNow;
               pendTaken_d = brTakenNow;
            end else begin
               outValid_d = 1'b1;
               result_d   = aluRes;
               brAddr_d   = brAddrNow;
               brTaken_d  = brTakenNow;
            end
         end else if (state_q == DONE) begin
            outValid_d = 1'b1;
            result_d   = mdResult;
            brAddr_d   = pendAddr_q;
            brTaken_d  = pendTaken_q;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         outValid_q  <= 1'b0;
         result_q    <= '0;
         brAddr_q    <= '0;
         brTaken_q   <= 1'b0;
         pendAddr_q  <= '0;
         pendTaken_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         outValid_q  <= outValid_d;
         result_q    <= result_d;
         brAddr_q    <= brAddr_d;
         brTaken_q   <= brTaken_d;
         pendAddr_q  <= pendAddr_d;
         pendTaken_q <= pendTaken_d;
      end
   end

endmodule

// File: tb/tb_ex_alu_muldiv.sv
// Directed bench for ex_alu_muldiv with hand-computed expected values.
module tb_ex_alu_muldiv;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  op;
   logic [31:0] rs_val, rt_val, ex_dm_fwd, dm_wb_fwd, pc_4;
   logic [1:0]  fwd_a, fwd_b;
   logic        imm_sel;
   logic [15:0] imm;
   logic        is_branch;
   logic        out_valid;
   logic [31:0] result, branch_addr;
   logic        branch_taken;

   int checks = 0;
   int errors = 0;

   ex_alu_muldiv dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .op           (op),
      .rs_val       (rs_val),
      .rt_val       (rt_val),
      .ex_dm_fwd    (ex_dm_fwd),
      .dm_wb_fwd    (dm_wb_fwd),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b),
      .imm_sel      (imm_sel),
      .imm          (imm),
      .pc_4         (pc_4),
      .is_branch    (is_branch),
      .out_valid    (out_valid),
      .result       (result),
      .branch_addr  (branch_addr),
      .branch_taken (branch_taken)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one op for a single rising edge, then sample #1 after it.
   task automatic applyStimulus(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [1:0] fa, input logic [1:0] fb, input logic isel,
                                input logic [15:0] im, input logic br);
      op        = o;
      rs_val    = a;
      rt_val    = b;
      fwd_a     = fa;
      fwd_b     = fb;
      imm_sel   = isel;
      imm       = im;
      is_branch = br;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      is_branch = 1'b0;
   endtask

   // Wait (bounded) for a long op to finish; check latency, in_ready and result.
   task automatic waitResult(input string tag, input logic [31:0] exp);
      int n = 0;
      logic readyLeak = 1'b0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (in_ready && !out_valid) readyLeak = 1'b1;
      end while (!out_valid && n < 40);
      checkOutput({tag, "_latency"}, 32'(n), 32'd34);
      checkOutput({tag, "_ready_low"}, {31'd0, readyLeak}, 32'd0);
      checkOutput(tag, result, exp);
   endtask

   // Count out_valid pulses over a window; none are expected.
   task automatic watchQuiet(input string tag, input int cycles);
      int pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) pulses++;
      end
      checkOutput(tag, 32'(pulses), 32'd0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op = 4'd0;
      rs_val = '0; rt_val = '0; ex_dm_fwd = '0; dm_wb_fwd = '0; pc_4 = '0;
      fwd_a = 2'd0; fwd_b = 2'd0; imm_sel = 1'b0; imm = '0; is_branch = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("reset_result", result, 32'd0);
      checkOutput("reset_branch_addr", branch_addr, 32'd0);
      checkOutput("reset_branch_taken", {31'd0, branch_taken}, 32'd0);
      checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);

      // ADD with A forwarded from EX/DM: 100 + 7
      ex_dm_fwd = 32'd100;
      applyStimulus(4'd0, 32'd5, 32'd7, 2'b01, 2'b00, 1'b0, 16'h0000, 1'b0);
      checkOutput("add_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("add_result", result, 32'd107);

      applyStimulus(4'd1, 32'd3, 32'd5, 2'b00, 2'b00, 1'b0, 16'h0000, 1'b0);
      checkOutput("sub_result", result, 32'hFFFF_FFFE);
      @(posedge clk);
      #1;
      checkOutput("valid_pulse", {31'd0, out_valid}, 32'd0);
      checkOutput("result_hold", result, 32'hFFFF_FFFE);

      // BEQ taken / not taken with negative immediate
      pc_4 = 32'h100;
      applyStimulus(4'd0, 32'd9, 32'd9, 2'b00, 2'b00, 1'b0, 16'hFFFF, 1'b1);
      checkOutput("beq_taken", {31'd0, branch_taken}, 32'd1);
      checkOutput("beq_addr", branch_addr, 32'h0000_00FC);
      applyStimulus(4'd0, 32'd9, 32'd8, 2'b00, 2'b00, 1'b0, 16'hFFFF, 1'b1);
      checkOutput("beq_not_taken", {31'd0, branch_taken}, 32'd0);

      // Immediate overrides forwarded B; compare still uses forwarded B (0x0F == 0x0F)
      dm_wb_fwd = 32'h0000_000F;
      applyStimulus(4'd3, 32'h0000_000F, 32'd0, 2'b00, 2'b10, 1'b1, 16'h8000, 1'b1);
      checkOutput("or_imm_result", result, 32'hFFFF_800F);
      checkOutput("imm_branch_uses_fwd", {31'd0, branch_taken}, 32'd1);

      applyStimulus(4'd5, 32'hFFFF_FFFF, 32'd1, 2'b00, 2'b00, 1'b0, 16'h0000, 1'b0);
      checkOutput("slt_signed", result, 32'd1);
      applyStimulus(4'd8, 32'h8000_0000, 32'h24, 2'b00, 2'b00, 1'b0, 16'h0000, 1'b0);
      checkOutput("sra_result", result, 32'hF800_0000);
      applyStimulus(4'd7, 32'h8000_0000, 32'h24, 2'b00, 2'b00, 1'b0, 16'h0000, 1'b0);
      checkOutput("srl_result", result, 32'h0800_0000);
      applyStimulus(4'd6, 32'd1, 32'd31, 2'b00, 2'b00, 1'b0, 16'h0000, 1'b0);
      checkOutput("sll_result", result, 32'h8000_0000);
      applyStimulus(4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'b00, 2'b00, 1'b0, 16'h0000, 1'b0);
      checkOutput("xor_result", result, 32'h0FF0_0FF0);
      applyStimulus(4'd15, 32'd2, 32'd3, 2'b11, 2'b11, 1'b0, 16'h0000, 1'b0);
      checkOutput("op15_as_add", result, 32'd5);

      // Multicycle ops; branch outputs captured at acceptance
      pc_4 = 32'h200;
      applyStimulus(4'd9, 32'hFFFF_FFFF, 32'd3, 2'b00, 2'b00, 1'b0, 16'h0001, 1'b0);
      checkOutput("mul_ready_after_accept", {31'd0, in_ready}, 32'd0);
      waitResult("mul_neg", 32'hFFFF_FFFD);
      checkOutput("mul_branch_addr", branch_addr, 32'h0000_0204);
      applyStimulus(4'd10, 32'hFFFF_FFFF, 32'd3, 2'b00, 2'b00, 1'b0, 16'h0000, 1'b0);
      waitResult("mulh_neg", 32'hFFFF_FFFF);
      applyStimulus(4'd9, 32'd7, 32'd6, 2'b00, 2'b00, 1'b0, 16'h0000, 1'b0);
      waitResult("mul_pos", 32'd42);
      applyStimulus(4'd11, 32'hFFFF_FFF9, 32'd2, 2'b00, 2'b00, 1'b0, 16'h0000, 1'b0);
      waitResult("div_neg", 32'hFFFF_FFFD);
      applyStimulus(4'd12, 32'hFFFF_FFF9, 32'd2, 2'b00, 2'b00, 1'b0, 16'h0000, 1'b0);
      waitResult("rem_neg", 32'hFFFF_FFFF);
      applyStimulus(4'd11, 32'd5, 32'd0, 2'b00, 2'b00, 1'b0, 16'h0000, 1'b0);
      waitResult("div_by_zero", 32'hFFFF_FFFF);
      applyStimulus(4'd12, 32'd5, 32'd0, 2'b00, 2'b00, 1'b0, 16'h0000, 1'b0);
      waitResult("rem_by_zero", 32'd5);
      applyStimulus(4'd11, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 2'b00, 1'b0, 16'h0000, 1'b0);
      waitResult("div_overflow", 32'h8000_0000);
      applyStimulus(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 2'b00, 1'b0, 16'h0000, 1'b0);
      waitResult("rem_overflow", 32'd0);

      // Flush a running divide; an op offered alongside flush is ignored
      applyStimulus(4'd11, 32'd100, 32'd7, 2'b00, 2'b00, 1'b0, 16'h0000, 1'b0);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      flush = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("flush_no_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("flush_ready", {31'd0, in_ready}, 32'd1);
      op = 4'd0; rs_val = 32'd1; rt_val = 32'd1; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush = 1'b0;
      checkOutput("flush_blocks_accept", {31'd0, out_valid}, 32'd0);
      watchQuiet("flush_no_stale_valid", 40);
      applyStimulus(4'd0, 32'd1, 32'd1, 2'b00, 2'b00, 1'b0, 16'h0000, 1'b1);
      checkOutput("post_flush_add_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("post_flush_add", result, 32'd2);
      checkOutput("post_flush_taken", {31'd0, branch_taken}, 32'd1);

      // Asynchronous reset in the middle of a multiply
      applyStimulus(4'd9, 32'd7, 32'd6, 2'b00, 2'b00, 1'b0, 16'h0000, 1'b0);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_rst_result", result, 32'd0);
      checkOutput("async_rst_addr", branch_addr, 32'd0);
      checkOutput("async_rst_taken", {31'd0, branch_taken}, 32'd0);
      checkOutput("async_rst_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rst_release_ready", {31'd0, in_ready}, 32'd1);
      watchQuiet("rst_no_stale_valid", 40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
